spi_slave_command_receiver: RTL
===============================

# spi_slave_command_receiver

Front end of the SPI slave path. Samples the raw SPI pins in the system clock domain and deframes SD‑style 48‑bit command frames: start bit 0, transmission bit 1, 6‑bit command, 32‑bit argument, CRC7, end bit 1. Drives `io_Command`, `io_CommandArgument` and `io_ArgumentReadFinished` directly into the downstream command consumer and the Avalon debug logger. Also reports CRC and framing status per frame.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for SCLK, CS_n and MOSI (≥2).
- `clock`  in  1  system clock. Must be ≥4× SCLK frequency.
- `reset`  in  1  asynchronous, active‑high reset.
- `io_SCLK`  in  1  SPI clock, mode 0, asynchronous to `clock`.
- `io_CS_n`  in  1  chip select, active low.
- `io_MOSI`  in  1  serial data, MSB first.
- `io_Command`  out  6  command index of the last completed argument.
- `io_CommandArgument`  out  32  argument of the last completed frame.
- `io_ArgumentReadFinished`  out  1  level; high from argument completion until the next start bit.
- `io_FrameDone`  out  1  one‑cycle pulse after the end bit is sampled.
- `io_CrcError`  out  1  CRC7 mismatch for the last frame; valid from `io_FrameDone`.
- `io_FramingError`  out  1  transmission bit ≠1 or end bit ≠1 in the last frame; valid from `io_FrameDone`.
- `io_Busy`  out  1  high while the FSM is outside IDLE and HUNT.

## Operation
- **Reset values.** All outputs are 0. FSM is in IDLE. Synchronizers are cleared to SCLK=0, CS_n=1, MOSI=1.
- **Sampling.** SCLK, CS_n and MOSI pass through `SYNC_STAGES` flops. A rising SCLK edge is detected when the synced SCLK was 0 on the previous cycle and is 1 now. MOSI is sampled on that cycle.
- **FSM states:** IDLE, HUNT, TXBIT, CMD, ARG, CRC, ENDBIT.
  - IDLE → HUNT when synced CS_n=0.
  - HUNT: on a sampled 0 → TXBIT, and `io_ArgumentReadFinished` clears on the same edge. A sampled 1 stays in HUNT (idle 0xFF bytes).
  - TXBIT: latch framing flag if the bit ≠1. Then go to CMD.
  - CMD: 6 bits. ARG: 32 bits. CRC: 7 bits. ENDBIT: 1 bit. Then back to HUNT.
  - A 6‑bit bit counter indexes each state and is reloaded on every state entry.
- **Shadow register.** Command and argument shift into a 38‑bit shadow register. `io_Command` and `io_CommandArgument` load from the shadow on the cycle after the 32nd argument bit. `io_ArgumentReadFinished` goes high in that same cycle.
- **CRC7.** Polynomial x^7+x^3+1, initial value 0. It is computed serially over the 40 bits start, tx, cmd and arg. The result is compared with the received CRC after the last CRC bit.
- **End of frame.** After the end bit, `io_FrameDone` pulses for one cycle. `io_CrcError` and `io_FramingError` update in that same cycle and hold until the next `io_FrameDone`.
- **CS_n deasserted at any point** → IDLE in the next cycle.
  - The shadow register is discarded. Outputs are not updated.
  - `io_ArgumentReadFinished` keeps its current value.
  - No `io_FrameDone` pulse.
- **CS_n deasserted during CRC or ENDBIT:** the argument outputs are already valid and stay valid. The frame is dropped with no `io_FrameDone`.
- **Asynchronous reset mid‑frame:** immediate return to reset values. No partial outputs.

## Timing
- `io_ArgumentReadFinished` rises `SYNC_STAGES`+1 clock cycles after the SCLK rising edge of argument bit 0 (the LSB).
- `io_FrameDone` rises `SYNC_STAGES`+1 cycles after the SCLK edge of the end bit.
- `io_Command` and `io_CommandArgument` change only in the cycle `io_ArgumentReadFinished` rises. They are stable for the whole time it is high.
- The downstream logger detects the 0→1 transition of `io_ArgumentReadFinished`. Back‑to‑back frames therefore always present a low period, from the next start bit until the next argument completes.
- SCLK high and low phases must each be ≥2 clock periods. Behaviour is undefined otherwise.

## Structure
- **Shared package `spi_slave_pkg`:**
  - FSM state enum.
  - Field widths: CMD_W=6, ARG_W=32, CRC_W=7, FRAME_BITS=48.
  - CRC7 polynomial constant 7'h09.
  - CRC7 single‑bit update function.
- **One sub‑module `spi_pin_synchronizer`:** `SYNC_STAGES`‑deep flops for all three pins, plus SCLK rising‑edge strobe generation.

## Test plan
- **CMD0.** CS_n low, send 0xFF, then 40 00 00 00 00 95 → `io_Command`=0, `io_CommandArgument`=0, `io_CrcError`=0, `io_FramingError`=0, one `io_FrameDone` pulse.
- **CMD17.** Send 51 00 00 12 34 CRC(correct) → `io_Command`=6'd17, `io_CommandArgument`=32'h00001234. `io_ArgumentReadFinished` rises exactly once, before `io_FrameDone`.
- **Bad CRC, then bad end bit.** CMD0 frame with CRC byte 0x97 → `io_CrcError`=1. Same frame with end bit 0 → `io_FramingError`=1. Argument outputs are updated in both cases.
- **CS abort.** Deassert CS_n after 20 argument bits of a CMD8 frame → outputs keep the previous frame's values, no `io_FrameDone`. FSM returns to IDLE, and a following CMD0 frame decodes correctly.
- **Back‑to‑back.** CMD55 then CMD41 with arg 0x40000000 and no gap → `io_ArgumentReadFinished` drops at the second start bit and rises again with `io_Command`=41.
- **Reset mid‑argument.** Assert reset during the ARG state → all outputs 0 immediately; the next full frame decodes correctly.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared types, field widths and CRC7 helper for the SPI slave command path.
package spi_slave_pkg;

    localparam int CMD_W      = 6;
    localparam int ARG_W      = 32;
    localparam int CRC_W      = 7;
    localparam int FRAME_BITS = 48;
    localparam int SHADOW_W   = CMD_W + ARG_W;

    localparam logic [CRC_W-1:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_TXBIT,
        ST_CMD,
        ST_ARG,
        ST_CRC,
        ST_ENDBIT
    } state_e;

    function automatic logic [CRC_W-1:0] crc7_next(
        input logic [CRC_W-1:0] crc,
        input logic             b
    );
        logic fb;
        fb = crc[CRC_W-1] ^ b;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
    endfunction

endpackage

// File: rtl/spi_slave_command_receiver_if.sv
// Raw SPI pin bundle: the bus master drives it, the slave front end samples it.
interface spi_slave_command_receiver_if;

    logic sclk;
    logic cs_n;
    logic mosi;

    modport master (output sclk, output cs_n, output mosi);
    modport slave  (input  sclk, input  cs_n, input  mosi);

endinterface

// File: rtl/spi_pin_synchronizer.sv
// Multi-flop synchronizers for the SPI pins plus a rising-SCLK strobe.
module spi_pin_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    spi_slave_command_receiver_if.slave   pins,
    output logic                          cs_n_o,
    output logic                          mosi_o,
    output logic                          sclk_rise_o
);

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] cs_n_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   sclk_prev_q;

    // Idle bus levels on reset so nothing looks like a select or an edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sclk_q      <= '0;
            cs_n_q      <= '1;
            mosi_q      <= '1;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[SYNC_STAGES-2:0], pins.sclk};
            cs_n_q      <= {cs_n_q[SYNC_STAGES-2:0], pins.cs_n};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], pins.mosi};
            sclk_prev_q <= sclk_q[SYNC_STAGES-1];
        end
    end

    assign cs_n_o      = cs_n_q[SYNC_STAGES-1];
    assign mosi_o      = mosi_q[SYNC_STAGES-1];
    assign sclk_rise_o = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;

endmodule

// File: rtl/spi_slave_command_receiver.sv
// SD-style 48-bit command frame deframer with CRC7 and framing status.
module spi_slave_command_receiver
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_SCLK,
    input  logic             io_CS_n,
    input  logic             io_MOSI,
    output logic [CMD_W-1:0] io_Command,
    output logic [ARG_W-1:0] io_CommandArgument,
    output logic             io_ArgumentReadFinished,
    output logic             io_FrameDone,
    output logic             io_CrcError,
    output logic             io_FramingError,
    output logic             io_Busy
);

    spi_slave_command_receiver_if pins ();

    assign pins.sclk = io_SCLK;
    assign pins.cs_n = io_CS_n;
    assign pins.mosi = io_MOSI;

    logic cs_n_s;
    logic mosi_s;
    logic rise_s;

    spi_pin_synchronizer #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock       (clock),
        .reset       (reset),
        .pins        (pins),
        .cs_n_o      (cs_n_s),
        .mosi_o      (mosi_s),
        .sclk_rise_o (rise_s)
    );

    state_e              state_q;
    logic [5:0]          cnt_q;
    logic [SHADOW_W-1:0] shadow_q;
    logic [CRC_W-1:0]    crc_q;
    logic [CRC_W-1:0]    rxcrc_q;
    logic                crc_bad_q;
    logic                txerr_q;
    logic [CMD_W-1:0]    cmd_q;
    logic [ARG_W-1:0]    arg_q;
    logic                arf_q;
    logic                done_q;
    logic                crc_err_q;
    logic                frm_err_q;

    logic [SHADOW_W-1:0] shadow_d;
    logic [CRC_W-1:0]    rxcrc_d;

    assign shadow_d = {shadow_q[SHADOW_W-2:0], mosi_s};
    assign rxcrc_d  = {rxcrc_q[CRC_W-2:0], mosi_s};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shadow_q  <= '0;
            crc_q     <= '0;
            rxcrc_q   <= '0;
            crc_bad_q <= 1'b0;
            txerr_q   <= 1'b0;
            cmd_q     <= '0;
            arg_q     <= '0;
            arf_q     <= 1'b0;
            done_q    <= 1'b0;
            crc_err_q <= 1'b0;
            frm_err_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // Deselect drops the frame; published outputs stay untouched.
            if (cs_n_s && state_q != ST_IDLE) begin
                state_q  <= ST_IDLE;
                shadow_q <= '0;
            end else if (state_q == ST_IDLE) begin
                if (!cs_n_s) state_q <= ST_HUNT;
            end else if (rise_s) begin
                unique case (state_q)
                    ST_HUNT: begin
                        if (!mosi_s) begin
                            state_q <= ST_TXBIT;
                            cnt_q   <= '0;
                            arf_q   <= 1'b0;
                            crc_q   <= crc7_next('0, mosi_s);
                        end
                    end
                    ST_TXBIT: begin
                        txerr_q <= !mosi_s;
                        crc_q   <= crc7_next(crc_q, mosi_s);
                        state_q <= ST_CMD;
                        cnt_q   <= 6'(CMD_W - 1);
                    end
                    ST_CMD: begin
                        shadow_q <= shadow_d;
                        crc_q    <= crc7_next(crc_q, mosi_s);
                        cnt_q    <= cnt_q - 6'd1;
                        if (cnt_q == '0) begin
                            state_q <= ST_ARG;
                            cnt_q   <= 6'(ARG_W - 1);
                        end
                    end
                    ST_ARG: begin
                        shadow_q <= shadow_d;
                        crc_q    <= crc7_next(crc_q, mosi_s);
                        cnt_q    <= cnt_q - 6'd1;
                        if (cnt_q == '0) begin
                            state_q <= ST_CRC;
                            cnt_q   <= 6'(CRC_W - 1);
                            cmd_q   <= shadow_d[SHADOW_W-1:ARG_W];
                            arg_q   <= shadow_d[ARG_W-1:0];
                            arf_q   <= 1'b1;
                        end
                    end
                    ST_CRC: begin
                        rxcrc_q <= rxcrc_d;
                        cnt_q   <= cnt_q - 6'd1;
                        if (cnt_q == '0) begin
                            crc_bad_q <= (rxcrc_d != crc_q);
                            state_q   <= ST_ENDBIT;
                            cnt_q     <= '0;
                        end
                    end
                    ST_ENDBIT: begin
                        done_q    <= 1'b1;
                        crc_err_q <= crc_bad_q;
                        frm_err_q <= txerr_q | !mosi_s;
                        state_q   <= ST_HUNT;
                        cnt_q     <= '0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign io_Command              = cmd_q;
    assign io_CommandArgument      = arg_q;
    assign io_ArgumentReadFinished = arf_q;
    assign io_FrameDone            = done_q;
    assign io_CrcError             = crc_err_q;
    assign io_FramingError         = frm_err_q;
    assign io_Busy = (state_q != ST_IDLE) && (state_q != ST_HUNT);

endmodule
